// File: rtl/inst_fetch_fifo.sv
// Dual-port first-word-fall-through instruction buffer between the i_cache and dual-issue decode.
// Optional combinational empty-FIFO bypass is enabled by defining INST_FIFO_BYPASS_EN.
module inst_fetch_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_ok1,
  input  logic             in_ok2,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_inst2,
  input  logic [31:0]      in_pc2,
  input  logic             read_en1,
  input  logic             read_en2,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_pc1,
  output logic             out_valid1,
  output logic [31:0]      out_inst2,
  output logic [31:0]      out_pc2,
  output logic             out_valid2,
  output logic             empty,
  output logic             almost_full,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W:0]   AF_LVL  = (PTR_W+1)'(DEPTH - 4);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;

  logic             push1, push2;
  logic [1:0]       pushes, pop_st, byp_pops, wr_cnt;
  logic             stor_valid1, stor_valid2, byp_act;
  logic [PTR_W:0]   count_after_pop;
  logic [PTR_W+1:0] total;
  logic             accept;
  logic [31:0]      wr_inst_a, wr_pc_a;

  assign rd_ptr1     = rd_ptr + PTR_W'(1);
  assign wr_ptr1     = wr_ptr + PTR_W'(1);
  assign stor_valid1 = (count != '0);
  assign stor_valid2 = (count >= (PTR_W+1)'(2));

  assign push1  = in_ok1;
  assign push2  = in_ok1 & in_ok2;
  assign pushes = {1'b0, push1} + {1'b0, push2};
  assign pop_st = {1'b0, read_en1 & stor_valid1} + {1'b0, read_en1 & read_en2 & stor_valid2};

`ifdef INST_FIFO_BYPASS_EN
  // Words consumed straight off the cache ports never touch storage.
  assign byp_act  = (count == '0) && !flush;
  assign byp_pops = byp_act ? ({1'b0, read_en1 & push1} + {1'b0, read_en1 & read_en2 & push2})
                            : 2'd0;
`else
  assign byp_act  = 1'b0;
  assign byp_pops = 2'd0;
`endif

  assign wr_cnt          = pushes - byp_pops;
  assign count_after_pop = count - {{(PTR_W-1){1'b0}}, pop_st};
  assign total           = {1'b0, count_after_pop} + {{PTR_W{1'b0}}, wr_cnt};
  assign accept          = (total <= DEPTH_C);

  // If slot 1 was bypass-consumed, slot 2 becomes the first stored word.
  assign wr_inst_a = (byp_pops == 2'd1) ? in_inst2 : in_inst1;
  assign wr_pc_a   = (byp_pops == 2'd1) ? in_pc2   : in_pc1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_st);
      if (accept) begin
        if (wr_cnt != 2'd0) begin
          inst_mem[wr_ptr] <= wr_inst_a;
          pc_mem[wr_ptr]   <= wr_pc_a;
        end
        if (wr_cnt == 2'd2) begin
          inst_mem[wr_ptr1] <= in_inst2;
          pc_mem[wr_ptr1]   <= in_pc2;
        end
        wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
        count  <= total[PTR_W:0];
      end else begin
        count  <= count_after_pop;
      end
    end
  end

  always_comb begin
    out_inst1  = inst_mem[rd_ptr];
    out_pc1    = pc_mem[rd_ptr];
    out_valid1 = stor_valid1;
    out_inst2  = inst_mem[rd_ptr1];
    out_pc2    = pc_mem[rd_ptr1];
    out_valid2 = stor_valid2;
    if (byp_act) begin
      out_inst1  = in_inst1;
      out_pc1    = in_pc1;
      out_valid1 = push1;
      out_inst2  = in_inst2;
      out_pc2    = in_pc2;
      out_valid2 = push2;
    end
  end

  assign empty       = (count == '0);
  assign almost_full = (count >= AF_LVL);

endmodule
